tb_mmio_ctrl: RTL
=================

// Module: tb_mmio_ctrl
// PURPOSE
//  Address decoder and testbench MMIO target sitting directly downstream of axi2mem's memory port.
//  Forwards SRAM-region accesses to tb_sram unchanged; serves test-control space at MMIO_BASE:
//  - a scratch array
//  - an exit/status register
//  - a free-running cycle counter.
//  Merges read data back to axi2mem with the same 1-cycle read latency tb_sram has.
// PARAMETERS
//  AXI_ADDR_WIDTH  64            address width of memory port
//  AXI_DATA_WIDTH  64            data width; byte enables = AXI_DATA_WIDTH/8
//  NUM_WORDS       32768         SRAM words; SRAM region = [0, NUM_WORDS*AXI_DATA_WIDTH/8)
//  MMIO_BASE       64'h1100_0000 base of test-control space
//  NUM_SCRATCH     1024          scratch words (AXI_DATA_WIDTH each) at MMIO_BASE+0x0000
//  EXIT_OFFS       'h4000        exit register offset (write-only, sticky)
//  CYCLE_OFFS      'h4008        cycle counter offset (read-only)
// PORTS
//  clk_i         in   1        clock
//  rst_ni        in   1        asynchronous reset, active low
//  req_i         in   1        access strobe from axi2mem
//  we_i          in   1        1 = write, 0 = read
//  addr_i        in   AW       byte address
//  be_i          in   DW/8     byte enables (writes only)
//  wdata_i       in   DW       write data
//  rdata_o       out  DW       read data, valid the cycle after a read req
//  sram_req_o    out  1        forwarded strobe (SRAM hit only)
//  sram_we_o     out  1        forwarded write enable
//  sram_addr_o   out  AW       forwarded byte address (unchanged)
//  sram_be_o     out  DW/8     forwarded byte enables
//  sram_wdata_o  out  DW       forwarded write data
//  sram_rdata_i  in   DW       tb_sram read data (registered address inside tb_sram)
//  exit_valid_o  out  1        program has signalled end of test
//  exit_code_o   out  32       wdata_i[31:1] of the exit write (0 = pass)
//  err_cnt_o     out  16       count of accesses to unmapped addresses (saturating)
// BEHAVIOUR
//  Decode (combinational, from addr_i, priority top-down):
//   - SRAM: addr_i < NUM_WORDS*DW/8.
//   - SCR: MMIO_BASE <= addr_i < MMIO_BASE + NUM_SCRATCH*DW/8.
//   - EXIT: addr_i[AW-1:3] == (MMIO_BASE+EXIT_OFFS)>>3.
//   - CYC: addr_i[AW-1:3] == (MMIO_BASE+CYCLE_OFFS)>>3.
//   - else UNMAPPED.
//  sram_*_o: sram_req_o = req_i & SRAM hit; other sram_* outputs are a pass-through; no added latency.
//  Scratch writes:
//   - Word index = (addr_i-MMIO_BASE)>>3.
//   - Byte i is written only when be_i[i] is set.
//   - Scratch resets to all-zero.
//  EXIT write: on the first write with be_i[0] & wdata_i[0], set exit_valid_o<=1 and exit_code_o<=wdata_i[31:1].
//   - Both are sticky until reset; later EXIT writes are ignored.
//   - A write with wdata_i[0]=0 is a no-op.
//  cycle_q: 64-bit, +1 every cycle from reset release, wraps 2^64-1 -> 0. Writes to CYC are ignored.
//  err_cnt_o: +1 on every req_i to UNMAPPED (read or write); saturates at 16'hFFFF.
//  Read path (1-cycle latency):
//   - On a read req, register rsel_q (SRAM/SCR/EXIT/CYC/UNMAP).
//   - SCR/CYC/EXIT/UNMAP data are also captured into rdq_q.
//   - SCR captures scratch[idx]; CYC captures cycle_q as sampled on the req cycle.
//   - EXIT captures {31'b0, exit_valid, exit_code} zero-extended.
//   - UNMAP returns 64'hDEAD_BEEF_DEAD_BEEF.
//   - rdata_o = (rsel_q==SRAM) ? sram_rdata_i : rdq_q.
//   - rsel_q/rdq_q hold until the next read req, matching tb_sram's hold-last-read behaviour.
//  Back-to-back: one access per cycle. A write never disturbs rsel_q/rdq_q. A write followed by a read of the same scratch word next cycle returns the new data.
//  Reset (async, any time, incl. mid-read):
//   - rsel_q = UNMAP, rdq_q = 0, so rdata_o = 0.
//   - exit_valid_o = 0, exit_code_o = 0, err_cnt_o = 0, cycle_q = 0, scratch = 0.
//   - sram_req_o follows req_i (combinational).
// STRUCTURE
//  tb_mmio_pkg:
//   - region_e {REG_SRAM, REG_SCR, REG_EXIT, REG_CYC, REG_UNMAP}
//   - EXIT_OFFS/CYCLE_OFFS defaults
//   - UNMAP_PATTERN constant.
//  One sub-module, tb_mmio_decode: the combinational addr_i -> region_e decoder plus scratch index; reused by the bench scoreboard.
//  The rest (scratch array, counters, read mux) is flat in tb_mmio_ctrl.
// TESTING
//  1. Write 0x539 to byte addr 0x4000 (be 0xFF), then read it -> sram_req_o=1 both cycles; rdata_o=0x539 the cycle after the read.
//  2. Write 0x2A<<32 to 0x1100_0004 (be 0xF0), then read 0x1100_0000 -> rdata_o=0x0000002A_00000000; sram_req_o stays 0.
//  3. Write 1 to 0x1100_4000 (be 0x0F) -> exit_valid_o=1, exit_code_o=0 next cycle; a later write of 0x7 leaves the code at 0.
//  4. Read 0x1100_4008, then read it again 10 cycles later -> the two rdata_o values differ by exactly 10.
//  5. Read 0x2000_0000, then write to it -> err_cnt_o=2; read returns 0xDEADBEEF_DEADBEEF; scratch and SRAM unchanged.
//  6. Issue an SCR read, assert rst_ni=0 before the data cycle -> rdata_o=0; exit_valid_o=0; err_cnt_o=0 immediately (async).

Source files
------------

// File: rtl/tb_mmio_pkg.sv
// Shared types and constants for the testbench MMIO target: the region
// tags produced by the address decoder, default register offsets inside
// the test-control space, and the data returned for unmapped reads.
package tb_mmio_pkg;

    // Region an access falls into; decode priority is top to bottom.
    typedef enum logic [2:0] {
        REG_SRAM  = 3'd0,
        REG_SCR   = 3'd1,
        REG_EXIT  = 3'd2,
        REG_CYC   = 3'd3,
        REG_UNMAP = 3'd4
    } region_e;

    // Default offsets of the single-word registers relative to MMIO_BASE.
    localparam logic [63:0] DEF_EXIT_OFFS  = 64'h0000_0000_0000_4000;
    localparam logic [63:0] DEF_CYCLE_OFFS = 64'h0000_0000_0000_4008;

    // Recognisable read data for addresses nothing answers to.
    localparam logic [63:0] UNMAP_PATTERN  = 64'hDEAD_BEEF_DEAD_BEEF;

endpackage

// File: rtl/tb_mmio_decode.sv
// Combinational address decoder for the testbench memory port.
// Classifies a byte address into SRAM / scratch / exit / cycle / unmapped
// and derives the scratch word index. Purely combinational so it can sit
// in front of both the RTL target and any checking logic.
module tb_mmio_decode
    import tb_mmio_pkg::*;
#(
    parameter int unsigned AW          = 64,
    parameter int unsigned DW          = 64,
    parameter int unsigned NUM_WORDS   = 32768,
    parameter int unsigned NUM_SCRATCH = 1024,
    parameter int unsigned IW          = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1,
    parameter logic [AW-1:0] MMIO_BASE  = AW'(64'h1100_0000),
    parameter logic [AW-1:0] EXIT_OFFS  = AW'(DEF_EXIT_OFFS),
    parameter logic [AW-1:0] CYCLE_OFFS = AW'(DEF_CYCLE_OFFS)
) (
    input  logic [AW-1:0] addr,
    output region_e       region,
    output logic [IW-1:0] scr_idx
);

    // Bytes per data word and the number of address bits inside one word.
    localparam int unsigned BW = DW / 8;
    localparam int unsigned OB = (BW > 1) ? $clog2(BW) : 0;

    // Region limits in byte addresses.
    localparam logic [AW-1:0] SRAM_END  = AW'(NUM_WORDS) * AW'(BW);
    localparam logic [AW-1:0] SCR_END   = MMIO_BASE + AW'(NUM_SCRATCH) * AW'(BW);
    localparam logic [AW-1:0] EXIT_ADDR = MMIO_BASE + EXIT_OFFS;
    localparam logic [AW-1:0] CYC_ADDR  = MMIO_BASE + CYCLE_OFFS;

    // Byte offset into the scratch array; only meaningful on a scratch hit.
    logic [AW-1:0] scr_offs;

    assign scr_offs = addr - MMIO_BASE;
    assign scr_idx  = IW'(scr_offs >> OB);

    // Priority decode: SRAM wins, then scratch, then the two word registers
    // (matched on the word address so any byte lane within them hits).
    always_comb begin
        region = REG_UNMAP;
        if (addr < SRAM_END) begin
            region = REG_SRAM;
        end else if ((addr >= MMIO_BASE) && (addr < SCR_END)) begin
            region = REG_SCR;
        end else if (addr[AW-1:OB] == EXIT_ADDR[AW-1:OB]) begin
            region = REG_EXIT;
        end else if (addr[AW-1:OB] == CYC_ADDR[AW-1:OB]) begin
            region = REG_CYC;
        end
    end

endmodule

// File: rtl/tb_mmio_ctrl.sv
// Testbench MMIO target sitting directly behind axi2mem's memory port.
// SRAM-region accesses are forwarded to tb_sram untouched; the test-control
// space at MMIO_BASE provides a scratch array, a sticky exit register and a
// free-running cycle counter. Read data from both sources is merged with
// the same one-cycle latency tb_sram has.
//
// Access protocol: req_i is a single-cycle strobe with no backpressure --
// the target accepts one access on every cycle req_i is high. we_i, addr_i,
// be_i and wdata_i qualify req_i in that same cycle. Read data for a read
// accepted in cycle N is on rdata_o in cycle N+1 and holds until the next
// read is accepted; writes never alter rdata_o.
module tb_mmio_ctrl
    import tb_mmio_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned NUM_WORDS      = 32768,
    parameter logic [AXI_ADDR_WIDTH-1:0] MMIO_BASE = AXI_ADDR_WIDTH'(64'h1100_0000),
    parameter int unsigned NUM_SCRATCH    = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] EXIT_OFFS  = AXI_ADDR_WIDTH'(DEF_EXIT_OFFS),
    parameter logic [AXI_ADDR_WIDTH-1:0] CYCLE_OFFS = AXI_ADDR_WIDTH'(DEF_CYCLE_OFFS)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   be_i,
    input  logic [AXI_DATA_WIDTH-1:0]     wdata_i,
    output logic [AXI_DATA_WIDTH-1:0]     rdata_o,
    output logic                          sram_req_o,
    output logic                          sram_we_o,
    output logic [AXI_ADDR_WIDTH-1:0]     sram_addr_o,
    output logic [AXI_DATA_WIDTH/8-1:0]   sram_be_o,
    output logic [AXI_DATA_WIDTH-1:0]     sram_wdata_o,
    input  logic [AXI_DATA_WIDTH-1:0]     sram_rdata_i,
    output logic                          exit_valid_o,
    output logic [31:0]                   exit_code_o,
    output logic [15:0]                   err_cnt_o
);

    localparam int unsigned AW = AXI_ADDR_WIDTH;
    localparam int unsigned DW = AXI_DATA_WIDTH;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned IW = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

    // Decoded region of the current access and its scratch word index.
    region_e       region;
    logic [IW-1:0] scr_idx;

    // Qualified strobes for the current cycle.
    logic rd_acc;
    logic wr_acc;

    // Test-control state.
    logic [DW-1:0] scratch [NUM_SCRATCH];
    logic [63:0]   cycle_q;
    logic          exit_valid_q;
    logic [31:0]   exit_code_q;
    logic [15:0]   err_cnt_q;

    // Read-return state: which source answers, and the locally sourced data.
    region_e       rsel_q;
    logic [DW-1:0] rdq_q;
    logic [DW-1:0] rd_next;

    tb_mmio_decode #(
        .AW          (AW),
        .DW          (DW),
        .NUM_WORDS   (NUM_WORDS),
        .NUM_SCRATCH (NUM_SCRATCH),
        .IW          (IW),
        .MMIO_BASE   (MMIO_BASE),
        .EXIT_OFFS   (EXIT_OFFS),
        .CYCLE_OFFS  (CYCLE_OFFS)
    ) u_decode (
        .addr    (addr_i),
        .region  (region),
        .scr_idx (scr_idx)
    );

    assign rd_acc = req_i & ~we_i;
    assign wr_acc = req_i &  we_i;

    // SRAM forwarding: only the strobe is gated, the rest passes straight through.
    assign sram_req_o   = req_i & (region == REG_SRAM);
    assign sram_we_o    = we_i;
    assign sram_addr_o  = addr_i;
    assign sram_be_o    = be_i;
    assign sram_wdata_o = wdata_i;

    // Byte-masked scratch writes; the whole array clears on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < int'(NUM_SCRATCH); w++) begin
                scratch[w] <= '0;
            end
        end else if (wr_acc && (region == REG_SCR)) begin
            for (int b = 0; b < int'(BW); b++) begin
                if (be_i[b]) begin
                    scratch[scr_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Exit register: the first write carrying a set pass/fail flag in byte 0
    // latches the code; everything after that is ignored until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exit_valid_q <= 1'b0;
            exit_code_q  <= '0;
        end else if (wr_acc && (region == REG_EXIT) && !exit_valid_q && be_i[0] && wdata_i[0]) begin
            exit_valid_q <= 1'b1;
            exit_code_q  <= {1'b0, wdata_i[31:1]};
        end
    end

    // Free-running cycle counter; wraps naturally at 2^64.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
        end
    end

    // Saturating count of accesses that hit nothing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (req_i && (region == REG_UNMAP) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    // Locally sourced read data, as seen in the request cycle.
    always_comb begin
        rd_next = '0;
        case (region)
            REG_SCR:   rd_next = scratch[scr_idx];
            REG_EXIT:  rd_next = DW'({exit_valid_q, exit_code_q});
            REG_CYC:   rd_next = DW'(cycle_q);
            REG_UNMAP: rd_next = DW'(UNMAP_PATTERN);
            default:   rd_next = '0;
        endcase
    end

    // Read-return registers: updated only by reads so the last read's data
    // holds across writes and idle cycles, like tb_sram's output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsel_q <= REG_UNMAP;
            rdq_q  <= '0;
        end else if (rd_acc) begin
            rsel_q <= region;
            if (region != REG_SRAM) begin
                rdq_q <= rd_next;
            end
        end
    end

    assign rdata_o      = (rsel_q == REG_SRAM) ? sram_rdata_i : rdq_q;
    assign exit_valid_o = exit_valid_q;
    assign exit_code_o  = exit_code_q;
    assign err_cnt_o    = err_cnt_q;

endmodule
